// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration chain loader.
package gpio_cfg_pkg;

    localparam int unsigned DEF_NUM_IO   = 38;
    localparam int unsigned DEF_CFG_BITS = 13;
    localparam int unsigned DEF_CLK_DIV  = 2;

    // Bit positions inside one pad configuration word.
    localparam int unsigned CFG_MGMT_EN       = 0;
    localparam int unsigned CFG_OUT_DIS       = 1;
    localparam int unsigned CFG_HOLD_OVERRIDE = 2;
    localparam int unsigned CFG_INP_DIS       = 3;
    localparam int unsigned CFG_IB_MODE_SEL   = 4;
    localparam int unsigned CFG_ANALOG_EN     = 5;
    localparam int unsigned CFG_ANALOG_SEL    = 6;
    localparam int unsigned CFG_ANALOG_POL    = 7;
    localparam int unsigned CFG_SLOW_SEL      = 8;
    localparam int unsigned CFG_VTRIP_SEL     = 9;
    localparam int unsigned CFG_DM_LSB        = 10;
    localparam int unsigned CFG_DM_MSB        = 12;

    // Same layout as a packed struct, MSB field first.
    typedef struct packed {
        logic [2:0] dm;
        logic       vtrip_sel;
        logic       slow_sel;
        logic       analog_pol;
        logic       analog_sel;
        logic       analog_en;
        logic       ib_mode_sel;
        logic       inp_dis;
        logic       hold_override;
        logic       out_dis;
        logic       mgmt_en;
    } pad_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT,
        ST_LOAD,
        ST_DONE
    } state_e;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_cfg_serializer_if.sv
// Control, register-file and pad-chain signals of the chain loader.
interface gpio_cfg_serializer_if #(
    parameter int unsigned NUM_IO   = gpio_cfg_pkg::DEF_NUM_IO,
    parameter int unsigned CFG_BITS = gpio_cfg_pkg::DEF_CFG_BITS
);
    localparam int unsigned PAD_W = gpio_cfg_pkg::idx_w(NUM_IO);

    logic                start;
    logic                busy;
    logic                done;
    logic [PAD_W-1:0]    cfg_addr;
    logic                cfg_rd;
    logic [CFG_BITS-1:0] cfg_data;
    logic                serial_clock;
    logic                serial_data_out;
    logic                serial_load;

    modport master (
        input  start, cfg_data,
        output busy, done, cfg_addr, cfg_rd,
        output serial_clock, serial_data_out, serial_load
    );

    modport slave (
        output start, cfg_data,
        input  busy, done, cfg_addr, cfg_rd,
        input  serial_clock, serial_data_out, serial_load
    );

endinterface

// File: rtl/gpio_cfg_clkgen.sv
// Phase counter: CLK_DIV cycles per serial_clock phase, plus phase/bit end strobes.
module gpio_cfg_clkgen #(
    parameter int unsigned CLK_DIV = gpio_cfg_pkg::DEF_CLK_DIV
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    input  logic sclk_en,
    output logic serial_clock,
    output logic phase_end_c,
    output logic bit_end_c
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_d;
    logic             phase;
    logic             phase_d;

    assign phase_end_c = run && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_end_c   = phase_end_c && phase;

    // Counter restarts in the low phase whenever the divider is not running.
    always_comb begin
        div_cnt_d = div_cnt;
        phase_d   = phase;
        if (!run) begin
            div_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (phase_end_c) begin
            div_cnt_d = '0;
            phase_d   = ~phase;
        end else begin
            div_cnt_d = div_cnt + DIV_W'(1);
        end
    end

    // Divider state and registered serial clock, gated to the shift state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_cnt      <= '0;
            phase        <= 1'b0;
            serial_clock <= 1'b0;
        end else begin
            div_cnt      <= div_cnt_d;
            phase        <= phase_d;
            serial_clock <= sclk_en && phase_d;
        end
    end

endmodule

// File: rtl/gpio_cfg_serializer.sv
// Fetches one config word per pad and shifts the chain out farthest pad first.
module gpio_cfg_serializer #(
    parameter int unsigned NUM_IO   = gpio_cfg_pkg::DEF_NUM_IO,
    parameter int unsigned CFG_BITS = gpio_cfg_pkg::DEF_CFG_BITS,
    parameter int unsigned CLK_DIV  = gpio_cfg_pkg::DEF_CLK_DIV
) (
    input  logic                  clock,
    input  logic                  resetn,
    gpio_cfg_serializer_if.master bus
);
    import gpio_cfg_pkg::*;

    localparam int unsigned PAD_W = idx_w(NUM_IO);
    localparam int unsigned BIT_W = idx_w(CFG_BITS);

    state_e              state;
    state_e              state_d;
    logic [PAD_W-1:0]    pad_idx;
    logic [PAD_W-1:0]    pad_idx_d;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_cnt_d;
    logic [CFG_BITS-1:0] shift_reg;
    logic [CFG_BITS-1:0] shift_reg_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic cfg_rd_q, cfg_rd_d;
    logic sdo_q, sdo_d;
    logic load_q, load_d;

    logic run_c;
    logic sclk_en_c;
    logic phase_end_c;
    logic bit_end_c;
    logic serial_clock;

    assign run_c     = (state == ST_SHIFT) || (state == ST_LOAD);
    assign sclk_en_c = (state_d == ST_SHIFT);

    gpio_cfg_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clock        (clock),
        .resetn       (resetn),
        .run          (run_c),
        .sclk_en      (sclk_en_c),
        .serial_clock (serial_clock),
        .phase_end_c  (phase_end_c),
        .bit_end_c    (bit_end_c)
    );

    // Next state, counters, shift register and next values of registered outputs.
    always_comb begin
        state_d     = state;
        pad_idx_d   = pad_idx;
        bit_cnt_d   = bit_cnt;
        shift_reg_d = shift_reg;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_FETCH;
                    pad_idx_d = PAD_W'(NUM_IO - 1);
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                shift_reg_d = bus.cfg_data;
                bit_cnt_d   = BIT_W'(CFG_BITS - 1);
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_end_c) begin
                    shift_reg_d = shift_reg << 1;
                    if (bit_cnt == '0) begin
                        if (pad_idx == '0) begin
                            state_d = ST_LOAD;
                        end else begin
                            pad_idx_d = pad_idx - PAD_W'(1);
                            state_d   = ST_FETCH;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt - BIT_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (phase_end_c) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        cfg_rd_d = (state_d == ST_FETCH);
        load_d   = (state_d == ST_LOAD);
        sdo_d    = (state_d == ST_SHIFT) ? shift_reg_d[CFG_BITS-1] : 1'b0;
    end

    // State register with datapath and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            pad_idx   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_rd_q  <= 1'b0;
            sdo_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state     <= state_d;
            pad_idx   <= pad_idx_d;
            bit_cnt   <= bit_cnt_d;
            shift_reg <= shift_reg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_rd_q  <= cfg_rd_d;
            sdo_q     <= sdo_d;
            load_q    <= load_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.cfg_rd          = cfg_rd_q;
    assign bus.cfg_addr        = pad_idx;
    assign bus.serial_clock    = serial_clock;
    assign bus.serial_data_out = sdo_q;
    assign bus.serial_load     = load_q;

endmodule
